// File: rtl/hp_alarm_pkg.sv
// Shared definitions for the hoggephase alarm monitor.
//   hp_state_t  : monitor FSM state, encoded as it appears on the state port
//   hp_clog2    : ceil(log2(value)), usable in parameter context
//   hit_width   : bits needed to hold a hit count of 0..thresh
//   timer_width : bits needed for the shared settle/window down-counter
package hp_alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMING  = 2'd1,
        ST_MONITOR = 2'd2,
        ST_TRIPPED = 2'd3
    } hp_state_t;

    function automatic int hp_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int hit_width(input int thresh);
        return hp_clog2(thresh + 1);
    endfunction

    // The timer only ever holds WINDOW-1 or ARM_DELAY-1, so clog2 of the
    // larger of the two is enough.
    function automatic int timer_width(input int window, input int arm_delay);
        return hp_clog2((window > arm_delay) ? window : arm_delay);
    endfunction

endpackage

// File: rtl/hp_alarm_sync.sv
// One detector lane: synchroniser, mask gate and saturating hit counter.
// Ports:
//   ck, rst      : system clock, async active-high reset
//   alarm        : raw detector alarm, asynchronous to ck
//   mask         : 1 = ignore this detector
//   hit_clr      : force the hit counter to 0 (highest priority)
//   count_en     : counting allowed (FSM is in MONITOR)
//   win_restart  : window boundary this cycle; restart count from v
//   v            : synchronised, masked alarm
//   hit_th       : one more hit would reach the threshold
module hp_alarm_sync
    import hp_alarm_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int THRESH      = 3
) (
    input  logic ck,
    input  logic rst,
    input  logic alarm,
    input  logic mask,
    input  logic hit_clr,
    input  logic count_en,
    input  logic win_restart,
    output logic v,
    output logic hit_th
);

    localparam int HIT_W = hit_width(THRESH);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [HIT_W-1:0]       hit;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], alarm};
    end

    assign v      = sync_q[SYNC_STAGES-1] & ~mask;
    assign hit_th = (hit >= HIT_W'(THRESH - 1));

    // At a window boundary the old count is dropped and a coincident hit
    // becomes the first hit of the new window.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            hit <= '0;
        end else if (hit_clr) begin
            hit <= '0;
        end else if (count_en) begin
            if (win_restart)
                hit <= HIT_W'(v);
            else if (v && hit != HIT_W'(THRESH))
                hit <= hit + HIT_W'(1);
        end
    end

endmodule

// File: rtl/hp_alarm_monitor.sv
// Tamper monitor for a bank of hoggephase glitch detectors. Synchronises
// and filters the raw alarms, latches a sticky tamper condition and emits
// a one-cycle zeroize pulse on a trip.
// Ports:
//   CK, RST     : system clock, async active-high reset
//   Alarm       : raw detector alarms (asynchronous)
//   mask        : 1 = ignore that detector
//   arm         : level, request monitoring
//   clear       : single-cycle, clear sticky state and counters
//   state       : FSM state (IDLE=0, ARMING=1, MONITOR=2, TRIPPED=3)
//   tamper      : sticky, high while TRIPPED
//   tamper_src  : sticky per-detector trip cause
//   zeroize     : one-cycle pulse on entry to TRIPPED
//   event_cnt   : saturating count of rising edges of OR(v)
//
// state   | meaning
// IDLE    | not monitoring, waiting for arm
// ARMING  | settle delay after arm, alarms ignored
// MONITOR | windowed hit counting, trip detection
// TRIPPED | tamper latched, only clear leaves
module hp_alarm_monitor
    import hp_alarm_pkg::*;
#(
    parameter int N_DET       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int THRESH      = 3,
    parameter int WINDOW      = 16,
    parameter int ARM_DELAY   = 8,
    parameter int CNT_W       = 16
) (
    input  logic             CK,
    input  logic             RST,
    input  logic [N_DET-1:0] Alarm,
    input  logic [N_DET-1:0] mask,
    input  logic             arm,
    input  logic             clear,
    output logic [1:0]       state,
    output logic             tamper,
    output logic [N_DET-1:0] tamper_src,
    output logic             zeroize,
    output logic [CNT_W-1:0] event_cnt
);

    localparam int               TMR_W    = timer_width(WINDOW, ARM_DELAY);
    localparam logic [TMR_W-1:0] ARM_LOAD = TMR_W'(ARM_DELAY - 1);
    localparam logic [TMR_W-1:0] WIN_LOAD = TMR_W'(WINDOW - 1);
    // At a window boundary a hit counts as the first of a new window, so it
    // can only trip on its own when a single hit is enough.
    localparam logic             EXP_TRIP = 1'(THRESH <= 1);

    hp_state_t        st;
    logic [TMR_W-1:0] tmr;
    logic [N_DET-1:0] v;
    logic [N_DET-1:0] hit_th;
    logic [N_DET-1:0] trip_vec;
    logic             any_q;
    logic             in_mon;
    logic             expiry;
    logic             hit_clr;
    logic             cnt_rise;

    assign state    = st;
    assign in_mon   = (st == ST_MONITOR);
    assign expiry   = in_mon && (tmr == '0);
    assign trip_vec = in_mon ? (v & (expiry ? {N_DET{EXP_TRIP}} : hit_th)) : '0;
    // Hit counters only matter in MONITOR; keeping them cleared elsewhere
    // guarantees a fresh start on every entry.
    assign hit_clr  = ~in_mon | clear | ~arm;
    // MONITOR and TRIPPED are the two states with bit 1 set.
    assign cnt_rise = (|v) & ~any_q & st[1];

    for (genvar i = 0; i < N_DET; i++) begin : g_det
        hp_alarm_sync #(
            .SYNC_STAGES(SYNC_STAGES),
            .THRESH     (THRESH)
        ) u_sync (
            .ck         (CK),
            .rst        (RST),
            .alarm      (Alarm[i]),
            .mask       (mask[i]),
            .hit_clr    (hit_clr),
            .count_en   (in_mon),
            .win_restart(expiry),
            .v          (v[i]),
            .hit_th     (hit_th[i])
        );
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            st         <= ST_IDLE;
            tmr        <= '0;
            tamper     <= 1'b0;
            tamper_src <= '0;
            zeroize    <= 1'b0;
            event_cnt  <= '0;
            any_q      <= 1'b0;
        end else begin
            zeroize <= 1'b0;
            any_q   <= |v;

            if (clear)
                event_cnt <= '0;
            else if (cnt_rise && event_cnt != {CNT_W{1'b1}})
                event_cnt <= event_cnt + CNT_W'(1);

            case (st)
                ST_IDLE: begin
                    if (arm) begin
                        st  <= ST_ARMING;
                        tmr <= ARM_LOAD;
                    end
                end
                ST_ARMING: begin
                    if (!arm) begin
                        st <= ST_IDLE;
                    end else if (tmr == '0) begin
                        st  <= ST_MONITOR;
                        tmr <= WIN_LOAD;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                ST_MONITOR: begin
                    tmr <= expiry ? WIN_LOAD : tmr - TMR_W'(1);
                    if (|trip_vec) begin
                        st         <= ST_TRIPPED;
                        tamper     <= 1'b1;
                        tamper_src <= tamper_src | trip_vec;
                        zeroize    <= 1'b1;
                    end else if (!arm) begin
                        st <= ST_IDLE;
                    end
                end
                ST_TRIPPED: begin
                    if (clear) begin
                        tamper     <= 1'b0;
                        tamper_src <= '0;
                        if (arm) begin
                            st  <= ST_ARMING;
                            tmr <= ARM_LOAD;
                        end else begin
                            st <= ST_IDLE;
                        end
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hp_alarm_monitor.sv
// Self-checking bench for hp_alarm_monitor (default parameters).
module tb_hp_alarm_monitor;

    localparam int N     = 4;
    localparam int SYNC  = 2;
    localparam int THR   = 3;
    localparam int WIN   = 16;
    localparam int ARMD  = 8;
    localparam int CMAX  = 65535;

    logic        CK = 1'b0;
    logic        RST = 1'b0;
    logic [3:0]  Alarm = '0;
    logic [3:0]  mask = '0;
    logic        arm = 1'b0;
    logic        clear = 1'b0;
    logic [1:0]  state;
    logic        tamper;
    logic [3:0]  tamper_src;
    logic        zeroize;
    logic [15:0] event_cnt;

    int total = 0;
    int bad   = 0;

    hp_alarm_monitor dut (
        .CK        (CK),
        .RST       (RST),
        .Alarm     (Alarm),
        .mask      (mask),
        .arm       (arm),
        .clear     (clear),
        .state     (state),
        .tamper    (tamper),
        .tamper_src(tamper_src),
        .zeroize   (zeroize),
        .event_cnt (event_cnt)
    );

    always #5 CK = ~CK;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    // Reference model: spec rules written directly over integers.
    int         m_pipe[N][SYNC];
    int         m_state, m_tmr, m_tamper, m_zero, m_cnt, m_prev_any;
    int         m_hit[N];
    logic [3:0] m_src;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_hit[i] = 0;
            for (int s = 0; s < SYNC; s++) m_pipe[i][s] = 0;
        end
        m_state = 0; m_tmr = 0; m_tamper = 0; m_zero = 0; m_cnt = 0;
        m_prev_any = 0; m_src = '0;
    endtask

    task automatic model_step();
        int v[N];
        int anyv, rise, expiry;
        logic [3:0] tb;
        anyv = 0;
        tb = '0;
        for (int i = 0; i < N; i++) begin
            v[i] = (m_pipe[i][SYNC-1] != 0 && mask[i] == 1'b0) ? 1 : 0;
            if (v[i] != 0) anyv = 1;
        end
        rise = (anyv != 0 && m_prev_any == 0) ? 1 : 0;
        for (int i = 0; i < N; i++) begin
            for (int s = SYNC - 1; s > 0; s--) m_pipe[i][s] = m_pipe[i][s-1];
            m_pipe[i][0] = Alarm[i] ? 1 : 0;
        end
        m_prev_any = anyv;
        m_zero = 0;
        if (clear) m_cnt = 0;
        else if (rise != 0 && m_state >= 2 && m_cnt < CMAX) m_cnt++;
        case (m_state)
            0: if (arm) begin m_state = 1; m_tmr = ARMD - 1; end
            1: begin
                if (!arm) m_state = 0;
                else if (m_tmr == 0) begin m_state = 2; m_tmr = WIN - 1; end
                else m_tmr--;
            end
            2: begin
                expiry = (m_tmr == 0) ? 1 : 0;
                for (int i = 0; i < N; i++)
                    if (v[i] != 0 && ((expiry != 0 ? 1 : m_hit[i] + 1) >= THR)) tb[i] = 1'b1;
                m_tmr = (expiry != 0) ? WIN - 1 : m_tmr - 1;
                for (int i = 0; i < N; i++) begin
                    if (expiry != 0) m_hit[i] = v[i];
                    else if (v[i] != 0 && m_hit[i] < THR) m_hit[i]++;
                end
                if (tb != 0) begin
                    m_state = 3; m_tamper = 1; m_src = m_src | tb; m_zero = 1;
                end else if (!arm) begin
                    m_state = 0;
                    for (int i = 0; i < N; i++) m_hit[i] = 0;
                end
                if (clear) for (int i = 0; i < N; i++) m_hit[i] = 0;
            end
            default: begin
                if (clear) begin
                    m_tamper = 0; m_src = '0;
                    for (int i = 0; i < N; i++) m_hit[i] = 0;
                    if (arm) begin m_state = 1; m_tmr = ARMD - 1; end
                    else m_state = 0;
                end
            end
        endcase
    endtask

    task automatic tick();
        model_step();
        @(posedge CK);
        #1;
        check("model_state", state, m_state);
        check("model_tamper", tamper, m_tamper);
        check("model_src", tamper_src, m_src);
        check("model_zeroize", zeroize, m_zero);
        check("model_cnt", event_cnt, m_cnt);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_state"}, state, 0);
        check({tag, "_tamper"}, tamper, 0);
        check({tag, "_src"}, tamper_src, 0);
        check({tag, "_zeroize"}, zeroize, 0);
        check({tag, "_cnt"}, event_cnt, 0);
    endtask

    task automatic do_reset();
        Alarm = '0; arm = 1'b0; clear = 1'b0;
        @(posedge CK);
        #1;
        RST = 1'b1;
        model_reset();
        #2;
        check_zero_outputs("reset");
        @(posedge CK);
        #1;
        RST = 1'b0;
    endtask

    task automatic go_monitor();
        int n;
        n = 0;
        arm = 1'b1;
        while (state != 2'd2 && n < 20) begin
            tick();
            n++;
        end
        check("reach_monitor", state, 2);
    endtask

    typedef struct {
        logic [3:0]  alarm;
        logic        arm;
        logic [1:0]  st;
        logic        tmp;
        logic [3:0]  src;
        logic        zer;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[15];

    initial begin
        // Arm sequence followed by a sustained glitch on detector 2.
        for (int i = 0; i < 8; i++) tbl[i] = '{4'h0, 1'b1, 2'd1, 1'b0, 4'h0, 1'b0, 16'd0};
        tbl[8]  = '{4'h0, 1'b1, 2'd2, 1'b0, 4'h0, 1'b0, 16'd0};
        tbl[9]  = '{4'h4, 1'b1, 2'd2, 1'b0, 4'h0, 1'b0, 16'd0};
        tbl[10] = '{4'h4, 1'b1, 2'd2, 1'b0, 4'h0, 1'b0, 16'd0};
        tbl[11] = '{4'h4, 1'b1, 2'd2, 1'b0, 4'h0, 1'b0, 16'd1};
        tbl[12] = '{4'h4, 1'b1, 2'd2, 1'b0, 4'h0, 1'b0, 16'd1};
        tbl[13] = '{4'h4, 1'b1, 2'd3, 1'b1, 4'h4, 1'b1, 16'd1};
        tbl[14] = '{4'h4, 1'b1, 2'd3, 1'b1, 4'h4, 1'b0, 16'd1};

        mask = '0;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            Alarm = tbl[i].alarm;
            arm   = tbl[i].arm;
            tick();
            check($sformatf("tbl%0d_state", i), state, tbl[i].st);
            check($sformatf("tbl%0d_tamper", i), tamper, tbl[i].tmp);
            check($sformatf("tbl%0d_src", i), tamper_src, tbl[i].src);
            check($sformatf("tbl%0d_zeroize", i), zeroize, tbl[i].zer);
            check($sformatf("tbl%0d_cnt", i), event_cnt, tbl[i].cnt);
        end

        // Sparse pulses: two per window for ten windows, never trips.
        do_reset();
        go_monitor();
        for (int t = 1; t <= 160; t++) begin
            Alarm = ((t % 16) == 3 || (t % 16) == 11) ? 4'b0001 : 4'b0000;
            tick();
        end
        Alarm = '0;
        for (int t = 0; t < 4; t++) tick();
        check("sparse_state", state, 2);
        check("sparse_tamper", tamper, 0);
        check("sparse_cnt", event_cnt, 20);

        // Window boundary: hits at timer 1 and 0, then two more in the next
        // window. The collision hit starts the new window, so the 4th trips.
        do_reset();
        go_monitor();
        for (int t = 1; t <= 30; t++) begin
            Alarm = (t == 13 || t == 14 || t == 18 || t == 22) ? 4'b0010 : 4'b0000;
            tick();
            if (t == 23) check("win_no_trip_yet", tamper, 0);
        end
        check("win_state", state, 3);
        check("win_tamper", tamper, 1);
        check("win_src", tamper_src, 4'b0010);
        check("win_cnt", event_cnt, 3);

        // Mask and ARMING: masked detector held high, another only in ARMING.
        do_reset();
        mask = 4'b0001;
        Alarm = 4'b1001;
        arm = 1'b1;
        for (int t = 0; t < 4; t++) tick();
        Alarm = 4'b0001;
        go_monitor();
        for (int t = 0; t < 20; t++) tick();
        check("mask_state", state, 2);
        check("mask_tamper", tamper, 0);
        check("mask_cnt", event_cnt, 0);
        mask = 4'b0000;
        for (int t = 0; t < 3; t++) tick();
        check("unmask_state", state, 3);
        check("unmask_src", tamper_src, 4'b0001);
        check("unmask_zeroize", zeroize, 1);

        // Clear out of TRIPPED with arm held goes back to ARMING.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_state", state, 1);
        check("clear_tamper", tamper, 0);
        check("clear_src", tamper_src, 0);
        check("clear_cnt", event_cnt, 0);
        begin
            int n;
            n = 0;
            while (state != 2'd3 && n < 30) begin
                tick();
                n++;
            end
            check("retrip_state", state, 3);
        end
        // Asynchronous reset in the middle of a cycle while TRIPPED.
        tick();
        #2;
        RST = 1'b1;
        #1;
        check_zero_outputs("async_rst");
        model_reset();
        @(posedge CK);
        #1;
        RST = 1'b0;
        Alarm = '0;

        // Randomised run against the reference model.
        mask = '0;
        do_reset();
        for (int t = 0; t < 800; t++) begin
            arm   = ($urandom % 20) != 0;
            clear = ($urandom % 40) == 0;
            if (($urandom % 100) == 0) mask = 4'($urandom);
            for (int i = 0; i < N; i++) Alarm[i] = ($urandom % 6) == 0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
